imem_prefetch: RTL
==================

IMEM_PREFETCH -- requirements
Module: imem_prefetch

Interface
REQ-001 Parameter ADDR_W, default 11, ROM word-address width (2^ADDR_W words).
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 32'h0040_0000, first fetch address and ROM base address.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 redirect_valid  in  1  branch/jump/exception redirect strobe.
REQ-008 redirect_pc  in  32  new fetch address; bits [1:0] ignored.
REQ-009 rom_en  out  1  synchronous-ROM read enable.
REQ-010 rom_addr  out  ADDR_W  ROM word address.
REQ-011 rom_data  in  DATA_W  ROM read data, valid the cycle after rom_en.
REQ-012 instr_valid  out  1  queue head holds an instruction.
REQ-013 instr  out  DATA_W  head instruction.
REQ-014 instr_pc  out  32  byte address of head instruction.
REQ-015 instr_ready  in  1  consumer accepts head; transfer when instr_valid && instr_ready.

Function
REQ-016 fetch_pc register SHALL hold the next byte address to issue; rom_addr = (fetch_pc - RESET_PC)[ADDR_W+1:2], wrapping modulo ROM depth.
REQ-017 rom_en SHALL assert when (count + inflight - pop) < DEPTH and no redirect this cycle; pop = instr_valid && instr_ready.
REQ-018 Each issue SHALL advance fetch_pc by 4, modulo 2^32, and set inflight (1 bit) with the issued pc as tag.
REQ-019 In the cycle after an issue, rom_data and its tag SHALL be written to the queue tail unless killed; inflight clears unless a new issue occurs.
REQ-020 Latency: issue in cycle N -> instr_valid, instr, instr_pc visible in cycle N+2; no bypass path.
REQ-021 instr/instr_pc SHALL come from the queue head; instr_valid = (count != 0).
REQ-022 Sustained throughput SHALL be one instruction per cycle while instr_ready stays high.
REQ-023 instr_valid SHALL not deassert and head data SHALL not change while instr_ready is low.
REQ-024 Redirect in cycle R: queue emptied and the in-flight response killed at R's edge; fetch_pc <= {redirect_pc[31:2],2'b00}; no issue in R; first new issue in R+1; first new instr_valid in R+3.
REQ-025 Redirect with simultaneous pop: the pop counts as accepted; the flush still empties the queue.
REQ-026 Push and pop in the same cycle on a full queue SHALL both succeed; count unchanged.
REQ-027 The queue SHALL never overflow; count + inflight <= DEPTH at all times.
REQ-028 Consecutive redirects in R and R+1 SHALL honour only the later target.

Reset
REQ-029 On rst_n low: fetch_pc = RESET_PC, count = 0, queue pointers = 0, inflight = 0, rom_en = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-030 Reset mid-operation SHALL discard all queued and in-flight data; first issue in the first cycle after rst_n is sampled high.

Structure
REQ-031 Shared package imem_pkg SHALL hold RESET_PC default, DATA_W default, and the {pc, instr} queue-entry type.
REQ-032 The queue SHALL be the sub-module imem_pf_fifo (DEPTH, entry width; push, pop, flush, count, head outputs).
REQ-033 The ROM SHALL remain external; this block contains no instruction storage.

Verification
REQ-034 Reset release, ROM word k = k, instr_ready high -> instr_valid in cycle 2; instr_pc 0x00400000, 0x00400004, ... one per cycle; instr = 0, 1, 2, ...
REQ-035 instr_ready low for 10 cycles -> exactly DEPTH=4 entries buffered, rom_en low when full, head stable; on release, 4 pops in back-to-back cycles then steady 1/cycle, no word lost or duplicated.
REQ-036 redirect_pc = 0x00400103 at cycle R -> queue empty at R+1, rom_addr = 0x40 at R+1, instr_pc = 0x00400100 at R+3; stale words never presented.
REQ-037 Redirect together with a pop, then a second redirect next cycle -> only second target appears; popped instruction counted once.
REQ-038 fetch_pc = RESET_PC + 4*(2^ADDR_W - 1) -> next rom_addr wraps to 0.
REQ-039 rst_n pulsed low for one cycle with queue full and read in flight -> all outputs zero during reset; fetch restarts at 0x00400000.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory prefetcher: defaults, queue entry
// layout, fetch-control states and the PC-to-ROM-word mapping.
package imem_pkg;

  localparam logic [31:0] IMEM_RESET_PC = 32'h0040_0000;
  localparam int          IMEM_DATA_W   = 32;

  typedef struct packed {
    logic [31:0]            pc;
    logic [IMEM_DATA_W-1:0] instr;
  } imem_entry_t;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_t;

  // Word offset of a byte address from the ROM base; callers truncate to the ROM depth.
  function automatic logic [29:0] word_offset(input logic [31:0] pc, input logic [31:0] base);
    logic [31:0] diff;
    diff = pc - base;
    return diff[31:2];
  endfunction

endpackage

// File: rtl/imem_prefetch_if.sv
// Bundle of redirect, synchronous-ROM and instruction-stream signals around the
// prefetcher; master is the prefetcher side, slave is the core/ROM side.
interface imem_prefetch_if import imem_pkg::*; #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = IMEM_DATA_W
);

  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [31:0]       instr_pc;
  logic              instr_ready;

  modport master (
    input  redirect_valid, redirect_pc, rom_data, instr_ready,
    output rom_en, rom_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, rom_data, instr_ready,
    input  rom_en, rom_addr, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/imem_pf_fifo.sv
// Power-of-two prefetch queue with flush; simultaneous push and pop on a full
// queue is accepted. Storage is data-only and carries no reset.
module imem_pf_fifo import imem_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter int  W     = 32 + IMEM_DATA_W,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [PW:0]  count,
  output logic [W-1:0] head
);

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/imem_prefetch.sv
// Instruction prefetcher: issues sequential reads to an external synchronous ROM,
// buffers {pc, instr} in a small queue and handles redirects by flushing.
module imem_prefetch import imem_pkg::*; #(
  parameter int          ADDR_W   = 11,
  parameter int          DATA_W   = IMEM_DATA_W,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IMEM_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_prefetch_if.master  bus
);

  localparam int PW      = $clog2(DEPTH);
  localparam int OW      = PW + 2;
  localparam int ENTRY_W = 32 + DATA_W;

  fetch_state_t       state_q;
  fetch_state_t       state_d;
  logic               run;
  logic [31:0]        fetch_pc;
  logic               issue;
  logic               pop;
  logic               push;
  logic [OW-1:0]      occ;
  logic               inflight_p1;
  logic [31:0]        tag_p1;
  logic [PW:0]        q_count;
  logic [ENTRY_W-1:0] q_head;
  logic [31:0]        head_pc;
  logic [DATA_W-1:0]  head_instr;

  // Fetch is held off for one cycle after reset release so the first issue lands
  // in the first cycle after rst_n is sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE: state_d = FS_RUN;
      FS_RUN:  state_d = FS_RUN;
    endcase
  end

  assign run = (state_q == FS_RUN);

  // Issue stage (p0): occupancy counts the queue, the read in flight and this cycle's pop.
  assign pop   = bus.instr_valid && bus.instr_ready;
  assign occ   = OW'(q_count) + OW'(inflight_p1) - OW'(pop);
  assign issue = run && !bus.redirect_valid && (occ < OW'(DEPTH));

  assign bus.rom_en   = issue;
  assign bus.rom_addr = ADDR_W'(word_offset(fetch_pc, RESET_PC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_p1 <= 1'b0;
    end else begin
      if (bus.redirect_valid) fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      else if (issue)         fetch_pc <= fetch_pc + 32'd4;
      inflight_p1 <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_p1 <= fetch_pc;
  end

  // Response stage (p1): ROM data lands and is queued unless a redirect kills it.
  assign push = inflight_p1 && !bus.redirect_valid;

  imem_pf_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({tag_p1, bus.rom_data}),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

  // Output stage: head is masked while empty so stale storage never leaks out.
  assign head_pc    = q_head[ENTRY_W-1:DATA_W];
  assign head_instr = q_head[DATA_W-1:0];

  assign bus.instr_valid = (q_count != '0);
  assign bus.instr       = bus.instr_valid ? head_instr : '0;
  assign bus.instr_pc    = bus.instr_valid ? head_pc    : 32'd0;

endmodule
